// File: rtl/bpm_mux_sequencer_if.sv
// Control, configuration and status bundle for bpm_mux_sequencer.
// Defining MUXSEQ_MISSED_TRIG_EN adds the o_missedTrigCnt status counter.
interface bpm_mux_sequencer_if #(
   parameter int MAX_BUNCH = 8
);
   logic                   i_enable;
   logic                   i_trig;
   logic [15:0]            i_cfgDelay;
   logic [7:0]             i_cfgIntLen;
   logic [7:0]             i_cfgGap;
   logic [3:0]             i_cfgNbunch;
   logic [2*MAX_BUNCH-1:0] i_cfgSelSeq;
   logic                   o_bunchStrb;
   logic [1:0]             o_sel;
   logic                   o_capValid;
   logic [3:0]             o_capBunch;
   logic                   o_busy;
   logic                   o_done;
   logic                   o_errCfg;

`ifdef MUXSEQ_MISSED_TRIG_EN
   logic [15:0]            o_missedTrigCnt;

   modport master (
      output i_enable, i_trig, i_cfgDelay, i_cfgIntLen, i_cfgGap, i_cfgNbunch, i_cfgSelSeq,
      input  o_bunchStrb, o_sel, o_capValid, o_capBunch, o_busy, o_done, o_errCfg, o_missedTrigCnt
   );
   modport slave (
      input  i_enable, i_trig, i_cfgDelay, i_cfgIntLen, i_cfgGap, i_cfgNbunch, i_cfgSelSeq,
      output o_bunchStrb, o_sel, o_capValid, o_capBunch, o_busy, o_done, o_errCfg, o_missedTrigCnt
   );
`else
   modport master (
      output i_enable, i_trig, i_cfgDelay, i_cfgIntLen, i_cfgGap, i_cfgNbunch, i_cfgSelSeq,
      input  o_bunchStrb, o_sel, o_capValid, o_capBunch, o_busy, o_done, o_errCfg
   );
   modport slave (
      input  i_enable, i_trig, i_cfgDelay, i_cfgIntLen, i_cfgGap, i_cfgNbunch, i_cfgSelSeq,
      output o_bunchStrb, o_sel, o_capValid, o_capBunch, o_busy, o_done, o_errCfg
   );
`endif
endinterface

// File: rtl/bpm_mux_sequencer.sv
// Drives the BPM integrator strobe/mux select per bunch and flags when each result is valid.
// Optional feature macro: MUXSEQ_MISSED_TRIG_EN (saturating count of triggers dropped while busy).
module bpm_mux_sequencer #(
   parameter int MAX_BUNCH = 8,
   parameter int GAP_MIN   = 10,
   parameter int CAP_LAT   = 2
) (
   input  logic               clk,
   input  logic               rst,
   bpm_mux_sequencer_if.slave bus
);

   typedef enum logic [2:0] {ST_IDLE, ST_DELAY, ST_INTEG, ST_GAP, ST_FLUSH} state_t;

   state_t                 r_state;
   logic [15:0]            r_cnt;
   logic [3:0]             r_bunch;
   logic [3:0]             r_nbunch;
   logic [7:0]             r_len;
   logic [7:0]             r_gap;
   logic [2*MAX_BUNCH-1:0] r_seq;
   logic [1:0]             r_sel;
   logic                   r_done;
   logic                   r_errCfg;
   logic [CAP_LAT-1:0]     r_capPipe;
   logic [3:0]             r_capIdx [CAP_LAT];

   state_t      w_stateNxt;
   logic [15:0] w_cntNxt;
   logic [3:0]  w_bunchNxt;
   logic [3:0]  w_bunchInc;
   logic [1:0]  w_selNxt;
   logic [1:0]  w_seqSel;
   logic        w_doneNxt;
   logic        w_errNxt;
   logic        w_capStart;
   logic        w_latch;
   logic        w_trigOk;
   logic        w_cfgValid;
   logic [7:0]  w_lenIn;
   logic [7:0]  w_gapIn;

   assign w_trigOk   = bus.i_trig & bus.i_enable;
   assign w_cfgValid = (bus.i_cfgNbunch != 4'd0) && (bus.i_cfgNbunch <= 4'(MAX_BUNCH));
   assign w_lenIn    = (bus.i_cfgIntLen == 8'd0) ? 8'd1 : bus.i_cfgIntLen;
   assign w_gapIn    = (bus.i_cfgGap < 8'(GAP_MIN)) ? 8'(GAP_MIN) : bus.i_cfgGap;
   assign w_bunchInc = r_bunch + 4'd1;

   always_comb begin
      w_seqSel = 2'b00;
      for (int n = 0; n < MAX_BUNCH; n++) begin
         if (w_bunchInc == 4'(n)) w_seqSel = r_seq[2*n +: 2];
      end
   end

   // r_cnt holds the cycles left in the current state after this one.
   // A trigger landing in the done cycle is dropped: the sequence is not yet considered idle.
   always_comb begin
      w_stateNxt = r_state;
      w_cntNxt   = r_cnt;
      w_bunchNxt = r_bunch;
      w_selNxt   = r_sel;
      w_doneNxt  = 1'b0;
      w_errNxt   = 1'b0;
      w_capStart = 1'b0;
      w_latch    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_trigOk && !r_done) begin
               if (!w_cfgValid) begin
                  w_errNxt = 1'b1;
               end else begin
                  w_latch    = 1'b1;
                  w_bunchNxt = 4'd0;
                  if (bus.i_cfgDelay == 16'd0) begin
                     w_stateNxt = ST_INTEG;
                     w_cntNxt   = {8'd0, w_lenIn - 8'd1};
                     w_selNxt   = bus.i_cfgSelSeq[1:0];
                  end else begin
                     w_stateNxt = ST_DELAY;
                     w_cntNxt   = bus.i_cfgDelay - 16'd1;
                  end
               end
            end
         end
         ST_DELAY: begin
            if (r_cnt == 16'd0) begin
               w_stateNxt = ST_INTEG;
               w_cntNxt   = {8'd0, r_len - 8'd1};
               w_selNxt   = r_seq[1:0];
            end else begin
               w_cntNxt = r_cnt - 16'd1;
            end
         end
         ST_INTEG: begin
            if (r_cnt == 16'd0) begin
               w_capStart = 1'b1;
               if (r_bunch == r_nbunch - 4'd1) begin
                  w_stateNxt = ST_FLUSH;
                  w_cntNxt   = 16'(GAP_MIN - 1);
               end else begin
                  w_stateNxt = ST_GAP;
                  w_cntNxt   = {8'd0, r_gap - 8'd1};
               end
            end else begin
               w_cntNxt = r_cnt - 16'd1;
            end
         end
         ST_GAP: begin
            if (r_cnt == 16'd0) begin
               w_stateNxt = ST_INTEG;
               w_cntNxt   = {8'd0, r_len - 8'd1};
               w_bunchNxt = w_bunchInc;
               w_selNxt   = w_seqSel;
            end else begin
               w_cntNxt = r_cnt - 16'd1;
            end
         end
         ST_FLUSH: begin
            if (r_cnt == 16'd0) begin
               w_stateNxt = ST_IDLE;
               w_doneNxt  = 1'b1;
            end else begin
               w_cntNxt = r_cnt - 16'd1;
            end
         end
         default: w_stateNxt = ST_IDLE;
      endcase
   end

   // The capture pipeline delays the end-of-strobe marker by CAP_LAT cycles with its bunch index.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_bunch   <= '0;
         r_nbunch  <= '0;
         r_len     <= '0;
         r_gap     <= '0;
         r_seq     <= '0;
         r_sel     <= '0;
         r_done    <= 1'b0;
         r_errCfg  <= 1'b0;
         r_capPipe <= '0;
         for (int i = 0; i < CAP_LAT; i++) r_capIdx[i] <= '0;
      end else begin
         r_state  <= w_stateNxt;
         r_cnt    <= w_cntNxt;
         r_bunch  <= w_bunchNxt;
         r_sel    <= w_selNxt;
         r_done   <= w_doneNxt;
         r_errCfg <= w_errNxt;
         if (w_latch) begin
            r_nbunch <= bus.i_cfgNbunch;
            r_len    <= w_lenIn;
            r_gap    <= w_gapIn;
            r_seq    <= bus.i_cfgSelSeq;
         end
         r_capPipe[0] <= w_capStart;
         r_capIdx[0]  <= r_bunch;
         for (int i = 1; i < CAP_LAT; i++) begin
            r_capPipe[i] <= r_capPipe[i-1];
            r_capIdx[i]  <= r_capIdx[i-1];
         end
      end
   end

   assign bus.o_bunchStrb = (r_state == ST_INTEG);
   assign bus.o_busy      = (r_state != ST_IDLE);
   assign bus.o_sel       = r_sel;
   assign bus.o_capValid  = r_capPipe[CAP_LAT-1];
   assign bus.o_capBunch  = r_capIdx[CAP_LAT-1];
   assign bus.o_done      = r_done;
   assign bus.o_errCfg    = r_errCfg;

`ifdef MUXSEQ_MISSED_TRIG_EN
   logic [15:0] r_missedCnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_missedCnt <= '0;
      end else if (w_trigOk && (r_state != ST_IDLE) && (r_missedCnt != 16'hFFFF)) begin
         r_missedCnt <= r_missedCnt + 16'd1;
      end
   end

   assign bus.o_missedTrigCnt = r_missedCnt;
`endif

endmodule
